// File: rtl/ws2812_decoder.sv
// rtl/ws2812_decoder.sv - WS2812 GRB pixel-stream decoder with 24-bit word output.
// Optional macro WS2812_DEC_FORWARD_EN: pass the rest of each frame to dout after its first word.
module ws2812_decoder #(
  parameter int T_MIN_HIGH = 8,
  parameter int T_THRESH   = 30,
  parameter int T_MAX_HIGH = 60,
  parameter int T_RESET    = 2500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic [23:0] pixel,
  output logic        pixel_valid,
  output logic        frame_done,
  output logic        error,
  output logic        dout
);

  localparam int CW = $clog2(T_RESET + 1);

  typedef enum logic [2:0] {
    WAIT_LATCH,
    IDLE,
    HIGH,
    LOW,
    FORWARD
  } state_t;

  state_t state, next_state;

  logic          din_s1, ds;
  logic [CW-1:0] hi_cnt, lo_cnt;
  logic [4:0]    bit_cnt;
  logic [23:0]   shift;

  logic latch_hit, bit_val;
  logic set_valid, set_error, set_frame, shift_en, clear_bits;

  // Fires exactly once per low stretch: the cycle the low count steps onto T_RESET.
  assign latch_hit = !ds && (lo_cnt == CW'(T_RESET - 1));
  assign bit_val   = (hi_cnt >= CW'(T_THRESH));

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_LATCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    set_valid  = 1'b0;
    set_error  = 1'b0;
    set_frame  = 1'b0;
    shift_en   = 1'b0;
    clear_bits = 1'b0;
    case (state)
      WAIT_LATCH: begin
        if (latch_hit) begin
          set_frame  = 1'b1;
          next_state = IDLE;
        end
      end
      IDLE: begin
        if (ds) next_state = HIGH;
      end
      HIGH: begin
        if (hi_cnt > CW'(T_MAX_HIGH)) begin
          set_error  = 1'b1;
          clear_bits = 1'b1;
          next_state = WAIT_LATCH;
        end else if (!ds) begin
          if (hi_cnt < CW'(T_MIN_HIGH)) begin
            set_error  = 1'b1;
            clear_bits = 1'b1;
            next_state = WAIT_LATCH;
          end else begin
            shift_en   = 1'b1;
            next_state = LOW;
            if (bit_cnt == 5'd23) begin
              set_valid = 1'b1;
`ifdef WS2812_DEC_FORWARD_EN
              next_state = FORWARD;
`endif
            end
          end
        end
      end
      LOW: begin
        if (ds) begin
          next_state = HIGH;
        end else if (latch_hit) begin
          set_frame  = 1'b1;
          set_error  = (bit_cnt != 5'd0);
          clear_bits = 1'b1;
          next_state = IDLE;
        end
      end
`ifdef WS2812_DEC_FORWARD_EN
      FORWARD: begin
        if (latch_hit) begin
          set_frame  = 1'b1;
          next_state = IDLE;
        end
      end
`endif
      default: next_state = WAIT_LATCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_s1      <= 1'b0;
      ds          <= 1'b0;
      hi_cnt      <= '0;
      lo_cnt      <= '0;
      bit_cnt     <= 5'd0;
      shift       <= 24'd0;
      pixel       <= 24'd0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
    end else begin
      din_s1 <= din;
      ds     <= din_s1;
      if (ds) begin
        hi_cnt <= (hi_cnt == CW'(T_RESET)) ? hi_cnt : hi_cnt + 1'b1;
        lo_cnt <= '0;
      end else begin
        lo_cnt <= (lo_cnt == CW'(T_RESET)) ? lo_cnt : lo_cnt + 1'b1;
        hi_cnt <= '0;
      end
      pixel_valid <= set_valid;
      frame_done  <= set_frame;
      error       <= set_error;
      if (clear_bits) begin
        bit_cnt <= 5'd0;
      end else if (shift_en) begin
        shift   <= {shift[22:0], bit_val};
        bit_cnt <= (bit_cnt == 5'd23) ? 5'd0 : bit_cnt + 5'd1;
        if (set_valid) pixel <= {shift[22:0], bit_val};
      end
    end
  end

`ifdef WS2812_DEC_FORWARD_EN
  assign dout = (state == FORWARD) && ds;
`else
  assign dout = 1'b0;
`endif

endmodule
